// File: rtl/fb_scan_arbiter.sv
// Framebuffer BRAM port arbiter: scan-out reads have absolute priority, a one-deep write holding
// register commits on free cycles. Optional macro FB_INTERLEAVE_EN frees non-sampled active cycles.
module fb_scan_arbiter #(
  parameter int unsigned FB_W   = 160,
  parameter int unsigned FB_H   = 120,
  parameter int unsigned SHIFT  = 2,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              valid,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [11:0]       wr_data,
  output logic              wr_drop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [11:0]       mem_din,
  input  logic [11:0]       mem_dout,
  output logic [11:0]       pixel_out,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam int unsigned FbSize = FB_W * FB_H;

  typedef enum logic {WIdle, WHold} wstate_e;

  wstate_e           state_q, state_d;
  logic [ADDR_W-1:0] h_addr_q, h_addr_d;
  logic [11:0]       h_data_q, h_data_d;
  logic [ADDR_W-1:0] addr_last_q, addr_last_d;
  logic [11:0]       din_last_q, din_last_d;
  logic              valid_d1_q;
  logic              hsync_d1_q, hsync_d2_q;
  logic              vsync_d1_q, vsync_d2_q;
  logic [11:0]       pixel_q, pixel_d;

  logic [9:0]        h_scaled, v_scaled;
  logic [ADDR_W-1:0] disp_addr;
  logic              need;
  logic              in_range;

  assign h_scaled  = h_cnt >> SHIFT;
  assign v_scaled  = v_cnt >> SHIFT;
  assign disp_addr = ADDR_W'(v_scaled) * ADDR_W'(FB_W) + ADDR_W'(h_scaled);

`ifdef FB_INTERLEAVE_EN
  // Only the first screen pixel of each framebuffer pixel needs a read.
  assign need = valid && (h_cnt[SHIFT-1:0] == '0);
`else
  assign need = valid;
`endif

  assign in_range = 32'(h_addr_q) < FbSize;

  always_comb begin
    state_d  = state_q;
    h_addr_d = h_addr_q;
    h_data_d = h_data_q;
    wr_ready = 1'b0;
    wr_drop  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = addr_last_q;
    mem_din  = din_last_q;

    if (reset) begin
      state_d  = WIdle;
      mem_addr = '0;
      mem_din  = '0;
    end else begin
      if (need) begin
        mem_addr = disp_addr;
      end
      case (state_q)
        WIdle: begin
          wr_ready = 1'b1;
          if (wr_valid) begin
            h_addr_d = wr_addr;
            h_data_d = wr_data;
            state_d  = WHold;
          end
        end
        WHold: begin
          // Display owns the port whenever it needs it; the write just waits.
          if (!need) begin
            mem_addr = h_addr_q;
            mem_din  = h_data_q;
            if (in_range) begin
              mem_we = 1'b1;
            end else begin
              wr_drop = 1'b1;
            end
            state_d = WIdle;
          end
        end
        default: state_d = WIdle;
      endcase
    end

    // The port holds its last address/data when nobody drives it.
    addr_last_d = mem_addr;
    din_last_d  = mem_din;
  end

`ifdef FB_INTERLEAVE_EN
  logic need_d1_q;

  always_ff @(posedge pclk) begin
    if (reset) begin
      need_d1_q <= 1'b0;
    end else begin
      need_d1_q <= need;
    end
  end

  always_comb begin
    pixel_d = pixel_q;
    if (!valid_d1_q) begin
      pixel_d = 12'h000;
    end else if (need_d1_q) begin
      pixel_d = mem_dout;
    end
  end
`else
  always_comb begin
    pixel_d = valid_d1_q ? mem_dout : 12'h000;
  end
`endif

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q     <= WIdle;
      h_addr_q    <= '0;
      h_data_q    <= '0;
      addr_last_q <= '0;
      din_last_q  <= '0;
      valid_d1_q  <= 1'b0;
      hsync_d1_q  <= 1'b1;
      hsync_d2_q  <= 1'b1;
      vsync_d1_q  <= 1'b1;
      vsync_d2_q  <= 1'b1;
      pixel_q     <= '0;
    end else begin
      state_q     <= state_d;
      h_addr_q    <= h_addr_d;
      h_data_q    <= h_data_d;
      addr_last_q <= addr_last_d;
      din_last_q  <= din_last_d;
      valid_d1_q  <= valid;
      hsync_d1_q  <= hsync;
      hsync_d2_q  <= hsync_d1_q;
      vsync_d1_q  <= vsync;
      vsync_d2_q  <= vsync_d1_q;
      pixel_q     <= pixel_d;
    end
  end

  assign pixel_out = pixel_q;
  assign hsync_out = hsync_d2_q;
  assign vsync_out = vsync_d2_q;

endmodule
